// File: rtl/inst_mem_pkg.sv
// Shared types and helpers for the instruction-fetch memory.
// Holds the fetch FSM states, the NOP constant and byte-address decoding.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic        err;
    logic [31:0] idx;
  } addr_map_t;

  // Word index plus error flag: misaligned, or any bit above the array range set.
  function automatic addr_map_t map_addr(input logic [63:0] addr,
                                         input int unsigned depth_log2);
    addr_map_t   m;
    logic [63:0] hi;
    hi    = addr >> (depth_log2 + 2);
    m.err = (addr[1:0] != 2'b00) || (hi != '0);
    m.idx = 32'((addr >> 2) & ((64'd1 << depth_log2) - 64'd1));
    return m;
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// DEPTH x DATA_W instruction storage: one synchronous write port and one
// synchronous read-enabled port; a same-edge collision returns the old word.
module inst_mem_array #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       DEPTH_LOG2 = 3,
  parameter logic [DATA_W-1:0] INIT       = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] widx_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] ridx_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  // Contents survive reset; only the read register is cleared.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: INIT};
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
    if (!rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[ridx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_rom.sv
// Instruction-fetch memory: one outstanding fetch, LATENCY wait states,
// req/ready -> rvalid handshake, range/alignment error flag and a load port.
module inst_rom
  import inst_mem_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DEPTH_LOG2 = 3,
  parameter int unsigned       LATENCY    = 1,
  parameter logic [DATA_W-1:0] RESET_INST = DATA_W'(NOP_INST)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic [ADDR_W-1:0]     addr_i,
  output logic                  ready_o,
  output logic                  rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  rerr_o,
  output logic                  busy_o,
  input  logic                  load_en_i,
  input  logic [DEPTH_LOG2-1:0] load_idx_i,
  input  logic [DATA_W-1:0]     load_data_i
);

  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rvalid_q, rvalid_d;
  logic                rerr_q, rerr_d;
  logic                busy_q, busy_d;

  logic                accept;
  logic                rd_fire;
  logic                rd_en;
  logic                idx_ok;
  logic [ADDR_W-1:0]   rd_addr;
  addr_map_t           rd_map;
  logic [DATA_W-1:0]   mem_rdata;

  assign ready_o = (state_q != WAIT) && rst;

  always_comb begin
    accept   = req_i && ready_o;
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rvalid_d = 1'b0;
    rerr_d   = rerr_q;
    busy_d   = 1'b0;
    rd_fire  = 1'b0;
    rd_addr  = addr_q;

    case (state_q)
      WAIT: begin
        if (cnt_q == '0) begin
          rd_fire = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          busy_d = 1'b1;
        end
      end
      default: begin
        if (accept) begin
          addr_d = addr_i;
          // Zero wait states read straight from the incoming address on the accept edge.
          if (LATENCY == 0) begin
            rd_fire = 1'b1;
            rd_addr = addr_i;
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    rd_map = map_addr(64'(rd_addr), DEPTH_LOG2);
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rerr_d   = rd_map.err;
    end
  end

  assign idx_ok = (rd_map.idx >> DEPTH_LOG2) == '0;
  assign rd_en  = rd_fire && !rd_map.err && idx_ok && rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      busy_q   <= busy_d;
    end
  end

  inst_mem_array #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2),
    .INIT      (RESET_INST)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .we_i   (load_en_i),
    .widx_i (load_idx_i),
    .wdata_i(load_data_i),
    .re_i   (rd_en),
    .ridx_i (rd_map.idx[DEPTH_LOG2-1:0]),
    .rdata_o(mem_rdata)
  );

  // The error flag stays registered with the response, so the NOP substitution holds too.
  assign rdata_o  = rerr_q ? RESET_INST : mem_rdata;
  assign rvalid_o = rvalid_q;
  assign rerr_o   = rerr_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_inst_rom.sv
// Directed bench for inst_rom: four instances at LATENCY 0..3 sharing clock,
// reset, address and load bus, each with its own request line.
module tb_inst_rom;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] addr;
  logic        load_en;
  logic [2:0]  load_idx;
  logic [31:0] load_data;
  logic [3:0]  ready, rvalid, rerr, busy;
  logic [31:0] rdata [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_rom #(.LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .req_i(req[0]), .addr_i(addr), .ready_o(ready[0]),
    .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .rerr_o(rerr[0]), .busy_o(busy[0]),
    .load_en_i(load_en), .load_idx_i(load_idx), .load_data_i(load_data));
  inst_rom #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_i(req[1]), .addr_i(addr), .ready_o(ready[1]),
    .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .rerr_o(rerr[1]), .busy_o(busy[1]),
    .load_en_i(load_en), .load_idx_i(load_idx), .load_data_i(load_data));
  inst_rom #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req_i(req[2]), .addr_i(addr), .ready_o(ready[2]),
    .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .rerr_o(rerr[2]), .busy_o(busy[2]),
    .load_en_i(load_en), .load_idx_i(load_idx), .load_data_i(load_data));
  inst_rom #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_i(req[3]), .addr_i(addr), .ready_o(ready[3]),
    .rvalid_o(rvalid[3]), .rdata_o(rdata[3]), .rerr_o(rerr[3]), .busy_o(busy[3]),
    .load_en_i(load_en), .load_idx_i(load_idx), .load_data_i(load_data));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input logic [31:0] d);
    load_en   = 1'b1;
    load_idx  = 3'(i);
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic fetch(input int k, input logic [31:0] a,
                       output logic [31:0] d, output logic e, output int cyc);
    addr   = a;
    req[k] = 1'b1;
    tick();
    req[k] = 1'b0;
    cyc    = 1;
    while (rvalid[k] !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("fetch_rvalid_seen", {31'd0, rvalid[k]}, 32'd1);
    d = rdata[k];
    e = rerr[k];
  endtask

  logic [31:0] prog [8] = '{32'h3C020001, 32'h3C010001, 32'h00411021, 32'h00410821,
                            32'h00411021, 32'h00410821, 32'h00411021, 32'h00410821};
  logic [31:0] d;
  logic        e;
  int          cyc;
  int          hits;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; req = '1; addr = '0; load_en = 1'b0; load_idx = '0; load_data = '0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ready",  {28'd0, ready},  32'h0);
      check("rst_rvalid", {28'd0, rvalid}, 32'h0);
      check("rst_rdata",  rdata[1],        32'h0);
    end
    req = '0;
    rst = 1'b1;
    #1;
    check("ready_after_rst", {28'd0, ready}, 32'hF);

    for (int i = 0; i < 8; i++) load(i, prog[i]);

    // LATENCY 0
    fetch(0, 32'h8, d, e, cyc);
    check("l0_data", d, 32'h00411021);
    check("l0_err",  {31'd0, e}, 32'd0);
    check("l0_lat",  32'(cyc), 32'd1);
    tick();
    check("l0_pulse", {31'd0, rvalid[0]}, 32'd0);

    // LATENCY 2, request held across two fetches
    addr = 32'h0; req[2] = 1'b1;
    tick();
    check("l2_ready_c1", {31'd0, ready[2]}, 32'd0);
    check("l2_busy_c1",  {31'd0, busy[2]},  32'd1);
    addr = 32'h4;
    tick();
    check("l2_ready_c2",  {31'd0, ready[2]},  32'd0);
    check("l2_rvalid_c2", {31'd0, rvalid[2]}, 32'd0);
    tick();
    check("l2_rvalid_c3", {31'd0, rvalid[2]}, 32'd1);
    check("l2_data_c3",   rdata[2], 32'h3C020001);
    check("l2_ready_c3",  {31'd0, ready[2]}, 32'd1);
    tick();
    check("l2_ready_c4", {31'd0, ready[2]}, 32'd0);
    tick();
    check("l2_ready_c5", {31'd0, ready[2]}, 32'd0);
    tick();
    check("l2_rvalid_c6", {31'd0, rvalid[2]}, 32'd1);
    check("l2_data_c6",   rdata[2], 32'h3C010001);
    req[2] = 1'b0;
    tick();
    check("l2_pulse", {31'd0, rvalid[2]}, 32'd0);

    // LATENCY 1: a good fetch then two errored ones
    fetch(1, 32'h4, d, e, cyc);
    check("l1_data", d, 32'h3C010001);
    check("l1_lat",  32'(cyc), 32'd2);
    fetch(1, 32'h20, d, e, cyc);
    check("err_range_err",  {31'd0, e}, 32'd1);
    check("err_range_data", d, 32'h0);
    fetch(1, 32'h6, d, e, cyc);
    check("err_align_err",  {31'd0, e}, 32'd1);
    check("err_align_data", d, 32'h0);
    fetch(1, 32'hC, d, e, cyc);
    check("err_clear_err",  {31'd0, e}, 32'd0);
    check("err_clear_data", d, 32'h00410821);
    tick();

    // Collision: load on the read edge returns the old word
    addr = 32'h4; req[1] = 1'b1;
    tick();
    req[1] = 1'b0;
    load_en = 1'b1; load_idx = 3'd1; load_data = 32'hDEADBEEF;
    tick();
    load_en = 1'b0;
    check("coll_same_rvalid", {31'd0, rvalid[1]}, 32'd1);
    check("coll_same_data",   rdata[1], 32'h3C010001);
    load(1, prog[1]);

    // Load one edge earlier is visible to the read
    addr = 32'h4; req[1] = 1'b1;
    load_en = 1'b1; load_idx = 3'd1; load_data = 32'hDEADBEEF;
    tick();
    req[1] = 1'b0; load_en = 1'b0;
    tick();
    check("coll_early_rvalid", {31'd0, rvalid[1]}, 32'd1);
    check("coll_early_data",   rdata[1], 32'hDEADBEEF);
    load(1, prog[1]);

    // LATENCY 3: reset one cycle after acceptance drops the fetch
    addr = 32'h8; req[3] = 1'b1;
    tick();
    req[3] = 1'b0;
    check("l3_busy_pre", {31'd0, busy[3]}, 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("l3_ready_post", {31'd0, ready[3]}, 32'd1);
    check("l3_busy_post",  {31'd0, busy[3]},  32'd0);
    check("l3_rdata_post", rdata[3], 32'h0);
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rvalid[3] === 1'b1) hits++;
    end
    check("l3_no_resp", 32'(hits), 32'd0);
    fetch(3, 32'h8, d, e, cyc);
    check("l3_data", d, 32'h00411021);
    check("l3_lat",  32'(cyc), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
